mem_access: RTL and testbench

Data-memory access unit for the Y86 pipeline's memory stage. It consumes the instruction fields held in the execute/memory pipeline register, performs the word read or write over a byte-serial data-memory bus, and drives a stall back to the upstream pipeline registers until the access completes. Its outputs feed the memory/write-back register (`valM`, error flag) and the pipeline hazard logic (`stall`).

---
 rtl/mem_access.sv | 198 +++++++++++++++++++
 tb/tb_mem_access.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: data-memory access unit for the Y86 memory stage.
//
// Decodes the execute/memory register fields. For a memory op it moves one
// 32-bit little-endian word over a byte-serial bus, one beat per byte. Until
// the access completes it holds the upstream pipeline with `stall`.
//
// Ports
//   clk         pipeline clock, rising edge
//   rst         asynchronous, active-low reset
//   in_icode    icode from the execute/memory register
//   in_valA     valA from the execute/memory register
//   in_valE     valE from the execute/memory register
//   in_valP     valP from the execute/memory register
//   stall       hold the execute/memory register and all upstream stages
//   valM        read word; valid with m_done and held until the next m_done
//   m_done      one-cycle pulse, the access finished this cycle
//   dmem_error  base address out of range; valid with m_done
//   bus_req     byte transfer request
//   bus_we      1 = write, 0 = read; valid with bus_req
//   bus_addr    byte address
//   bus_wdata   write byte
//   bus_rdata   read byte; valid with bus_ack
//   bus_ack     transfer complete this cycle
//   dbg_state   current FSM state (0 idle, 1 access, 2 done)
//
// Bus handshake: while bus_req is 1, bus_we, bus_addr and bus_wdata are held
// stable. A beat completes in the first cycle where bus_req and bus_ack are
// both 1. When bus_req is 0, bus_ack is ignored.
module mem_access #(
   parameter int MEM_SIZE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_icode,
   input  logic [31:0] in_valA,
   input  logic [31:0] in_valE,
   input  logic [31:0] in_valP,
   output logic        stall,
   output logic [31:0] valM,
   output logic        m_done,
   output logic        dmem_error,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ack,
   output logic [1:0]  dbg_state
);

   localparam logic [31:0] MAX_BASE = 32'(MEM_SIZE - 4);

   localparam logic [7:0] IC_RMMOVL = 8'h04;
   localparam logic [7:0] IC_MRMOVL = 8'h05;
   localparam logic [7:0] IC_CALL   = 8'h08;
   localparam logic [7:0] IC_RET    = 8'h09;
   localparam logic [7:0] IC_PUSHL  = 8'h0A;
   localparam logic [7:0] IC_POPL   = 8'h0B;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  beat_q;
   logic [7:0]  icode_q;
   logic [31:0] vala_q, vale_q, valp_q;
   logic        err_q;
   logic [23:0] rbuf_q;
   logic [31:0] valm_q;

   function automatic logic is_write(input logic [7:0] ic);
      return (ic == IC_RMMOVL) || (ic == IC_CALL) || (ic == IC_PUSHL);
   endfunction

   function automatic logic is_read(input logic [7:0] ic);
      return (ic == IC_MRMOVL) || (ic == IC_RET) || (ic == IC_POPL);
   endfunction

   // ret/popl address the stack through valA; all others use valE.
   function automatic logic [31:0] base_of(input logic [7:0] ic,
                                           input logic [31:0] a,
                                           input logic [31:0] e);
      return ((ic == IC_RET) || (ic == IC_POPL)) ? a : e;
   endfunction

   // Decode of the live inputs, used only in IDLE.
   logic        in_mem;
   logic [31:0] in_base;
   logic        in_err;

   assign in_mem  = is_write(in_icode) || is_read(in_icode);
   assign in_base = base_of(in_icode, in_valA, in_valE);
   // Unsigned compare: a base near 2^32 is out of range, with no wrap-around.
   assign in_err  = (in_base > MAX_BASE);

   // Decode of the captured operation, used during ACCESS.
   logic        cap_we;
   logic [31:0] cap_base;
   logic [31:0] cap_word;

   assign cap_we   = is_write(icode_q);
   assign cap_base = base_of(icode_q, vala_q, vale_q);
   assign cap_word = (icode_q == IC_CALL) ? valp_q : vala_q;

   assign valM      = valm_q;
   assign dbg_state = state_q;

   // Next state and outputs. Bus outputs are decoded from the state so that
   // an asynchronous reset drops bus_req at once.
   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      bus_req    = 1'b0;
      bus_we     = 1'b0;
      bus_addr   = 32'd0;
      bus_wdata  = 8'd0;
      m_done     = 1'b0;
      dmem_error = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_mem) begin
               stall   = 1'b1;
               state_d = in_err ? S_DONE : S_ACCESS;
            end
         end
         S_ACCESS: begin
            stall     = 1'b1;
            bus_req   = 1'b1;
            bus_we    = cap_we;
            bus_addr  = cap_base + {30'd0, beat_q};
            bus_wdata = cap_we ? cap_word[{beat_q, 3'b000} +: 8] : 8'd0;
            if (bus_ack && (beat_q == 2'd3)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            m_done     = 1'b1;
            dmem_error = err_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         beat_q  <= 2'd0;
         icode_q <= 8'd0;
         vala_q  <= 32'd0;
         vale_q  <= 32'd0;
         valp_q  <= 32'd0;
         err_q   <= 1'b0;
         rbuf_q  <= 24'd0;
         valm_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (in_mem) begin
                  icode_q <= in_icode;
                  vala_q  <= in_valA;
                  vale_q  <= in_valE;
                  valp_q  <= in_valP;
                  err_q   <= in_err;
                  beat_q  <= 2'd0;
                  // An errored access goes straight to DONE with valM 0.
                  if (in_err) begin
                     valm_q <= 32'd0;
                  end
               end
            end
            S_ACCESS: begin
               if (bus_ack) begin
                  beat_q <= beat_q + 2'd1;
                  if (!cap_we) begin
                     case (beat_q)
                        2'd0:    rbuf_q[7:0]   <= bus_rdata;
                        2'd1:    rbuf_q[15:8]  <= bus_rdata;
                        2'd2:    rbuf_q[23:16] <= bus_rdata;
                        default: ;
                     endcase
                  end
                  // Last beat: publish the word so valM is valid in DONE.
                  if (beat_q == 2'd3) begin
                     valm_q <= cap_we ? 32'd0 : {bus_rdata, rbuf_q};
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: a transaction-level model expands each op into
// its expected per-cycle trace; a bus responder with per-beat wait states
// serves the byte bus from its own memory image.
module tb_mem_access;

   localparam int MEM_SIZE = 1024;
   localparam logic [31:0] MAX_BASE = 32'(MEM_SIZE - 4);

   logic        clk;
   logic        rst;
   logic [7:0]  in_icode;
   logic [31:0] in_valA, in_valE, in_valP;
   logic        stall;
   logic [31:0] valM;
   logic        m_done;
   logic        dmem_error;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        bus_ack;
   logic [1:0]  dbg_state;

   mem_access #(.MEM_SIZE(MEM_SIZE)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_icode   (in_icode),
      .in_valA    (in_valA),
      .in_valE    (in_valE),
      .in_valP    (in_valP),
      .stall      (stall),
      .valM       (valM),
      .m_done     (m_done),
      .dmem_error (dmem_error),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_ack    (bus_ack),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic        stall;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [7:0]  wdata;
      logic        done;
      logic        err;
      logic [31:0] valm;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  ref_mem[MEM_SIZE];
   logic [7:0]  bus_mem[MEM_SIZE];
   logic [31:0] last_valm = 32'd0;

   // observation counters for the literal checks
   int          stall_cnt = 0;
   int          req_cnt = 0;
   int          done_cnt = 0;
   logic [31:0] seen_valm = 32'd0;
   logic        seen_err = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- bus responder ----------------
   int wait_q[$];
   int wait_left = 0;
   bit active = 1'b0;

   initial begin
      bus_ack   = 1'b0;
      bus_rdata = 8'd0;
   end

   always begin
      @(posedge clk);
      #2;
      if (rst && bus_req) begin
         if (!active) begin
            active    = 1'b1;
            wait_left = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
         end
         if (wait_left == 0) begin
            bus_ack   = 1'b1;
            bus_rdata = bus_mem[bus_addr % MEM_SIZE];
         end else begin
            bus_ack   = 1'b0;
            bus_rdata = 8'($urandom);
            wait_left--;
         end
      end else begin
         // spurious acks while idle must be ignored
         bus_ack   = 1'($urandom_range(0, 1));
         bus_rdata = 8'($urandom);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         active = 1'b0;
         wait_q.delete();
      end else if (bus_req && bus_ack) begin
         if (bus_we && (bus_addr < MEM_SIZE)) bus_mem[bus_addr] = bus_wdata;
         active = 1'b0;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (stall) stall_cnt++;
         if (bus_req) req_cnt++;
         if (m_done) begin
            done_cnt++;
            seen_valm = valM;
            seen_err  = dmem_error;
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", {31'd0, stall}, {31'd0, e.stall});
            chk("bus_req", {31'd0, bus_req}, {31'd0, e.req});
            chk("m_done", {31'd0, m_done}, {31'd0, e.done});
            chk("dmem_error", {31'd0, dmem_error}, {31'd0, e.err});
            chk("valM", valM, e.valm);
            if (e.req) begin
               chk("bus_addr", bus_addr, e.addr);
               chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
               if (e.we) chk("bus_wdata", {24'd0, bus_wdata}, {24'd0, e.wdata});
            end
         end
      end
   end

   // ---------------- model + driver ----------------
   // Builds the expected trace of one op from the timing rules, applies the
   // op and advances exactly as many cycles as the trace is long.
   // Entry/exit point: 1 time unit after a rising edge.
   task automatic run_op(input logic [7:0] ic, input logic [31:0] a, input logic [31:0] e,
                         input logic [31:0] p, input int wmin, input int wmax);
      exp_t        r;
      logic        wr, rd;
      logic [31:0] base, word, res;
      int          n, w;
      wr   = (ic == 8'h04) || (ic == 8'h08) || (ic == 8'h0A);
      rd   = (ic == 8'h05) || (ic == 8'h09) || (ic == 8'h0B);
      base = ((ic == 8'h09) || (ic == 8'h0B)) ? a : e;
      word = (ic == 8'h08) ? p : a;
      n    = 0;
      r    = '0;
      r.valm = last_valm;
      if (!(wr || rd)) begin
         exp_q.push_back(r);
         n = 1;
      end else begin
         r.stall = 1'b1;
         exp_q.push_back(r);
         n = 1;
         if (base > MAX_BASE) begin
            r = '0;
            r.done = 1'b1;
            r.err  = 1'b1;
            r.valm = 32'd0;
            last_valm = 32'd0;
            exp_q.push_back(r);
            n++;
         end else begin
            res = 32'd0;
            for (int k = 0; k < 4; k++) begin
               w = $urandom_range(wmax, wmin);
               wait_q.push_back(w);
               for (int c = 0; c <= w; c++) begin
                  r = '0;
                  r.stall = 1'b1;
                  r.req   = 1'b1;
                  r.we    = wr;
                  r.addr  = base + 32'(k);
                  r.wdata = word[8*k +: 8];
                  r.valm  = last_valm;
                  exp_q.push_back(r);
                  n++;
               end
               if (wr) ref_mem[base + 32'(k)] = word[8*k +: 8];
               else    res[8*k +: 8] = ref_mem[base + 32'(k)];
            end
            r = '0;
            r.done = 1'b1;
            r.valm = wr ? 32'd0 : res;
            last_valm = r.valm;
            exp_q.push_back(r);
            n++;
         end
      end
      in_icode = ic;
      in_valA  = a;
      in_valE  = e;
      in_valP  = p;
      stall_cnt = 0;
      req_cnt   = 0;
      done_cnt  = 0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bus_word(input int addr);
      return {bus_mem[addr+3], bus_mem[addr+2], bus_mem[addr+1], bus_mem[addr]};
   endfunction

   logic [7:0] ic_tab[12] = '{8'h04, 8'h05, 8'h08, 8'h09, 8'h0A, 8'h0B,
                              8'h00, 8'h01, 8'h02, 8'h03, 8'h06, 8'h07};

   initial begin
      int mism;
      logic [7:0]  ic;
      logic [31:0] addr, a, e, p;
      int sel;

      for (int i = 0; i < MEM_SIZE; i++) begin
         ref_mem[i] = 8'($urandom);
         bus_mem[i] = ref_mem[i];
      end
      ref_mem[32'h20] = 8'h78; bus_mem[32'h20] = 8'h78;
      ref_mem[32'h21] = 8'h56; bus_mem[32'h21] = 8'h56;
      ref_mem[32'h22] = 8'h34; bus_mem[32'h22] = 8'h34;
      ref_mem[32'h23] = 8'h12; bus_mem[32'h23] = 8'h12;

      // reset state
      rst = 1'b0;
      in_icode = 8'h05;
      in_valA = 32'd0;
      in_valE = 32'h20;
      in_valP = 32'd0;
      #3;
      chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
      chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
      chk("rst_valM", valM, 32'd0);
      chk("rst_m_done", {31'd0, m_done}, 32'd0);
      chk("rst_dmem_error", {31'd0, dmem_error}, 32'd0);
      chk("rst_stall_memop", {31'd0, stall}, 32'd1);
      in_icode = 8'h03;
      #1;
      chk("rst_stall_nonmem", {31'd0, stall}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;

      // read, zero-wait
      run_op(8'h05, 32'h0, 32'h20, 32'h0, 0, 0);
      chk("read_valM", seen_valm, 32'h12345678);
      chk("read_stall_cycles", 32'(stall_cnt), 32'd5);
      chk("read_done_cnt", 32'(done_cnt), 32'd1);

      // write with 2 wait cycles per beat
      run_op(8'h0A, 32'hDEADBEEF, 32'h100, 32'h0, 2, 2);
      chk("write_stall_cycles", 32'(stall_cnt), 32'd13);
      chk("write_valM", seen_valm, 32'd0);
      chk("write_mem", bus_word(32'h100), 32'hDEADBEEF);

      // ret uses valA; call writes valP at valE
      run_op(8'h09, 32'h40, 32'h999, 32'h0, 0, 2);
      chk("ret_req_cycles_min", {31'd0, 1'(req_cnt >= 4)}, 32'd1);
      run_op(8'h08, 32'h55, 32'h180, 32'h17, 0, 1);
      chk("call_mem", bus_word(32'h180), 32'h17);

      // out-of-range bases
      run_op(8'h05, 32'h0, 32'(MEM_SIZE - 3), 32'h0, 0, 0);
      chk("err1_stall", 32'(stall_cnt), 32'd1);
      chk("err1_flag", {31'd0, seen_err}, 32'd1);
      chk("err1_no_req", 32'(req_cnt), 32'd0);
      chk("err1_valM", seen_valm, 32'd0);
      run_op(8'h05, 32'h0, 32'hFFFFFFFE, 32'h0, 0, 0);
      chk("err2_stall", 32'(stall_cnt), 32'd1);
      chk("err2_flag", {31'd0, seen_err}, 32'd1);
      chk("err2_no_req", 32'(req_cnt), 32'd0);

      // highest valid base
      run_op(8'h05, 32'h0, MAX_BASE, 32'h0, 0, 1);
      chk("maxbase_err", {31'd0, seen_err}, 32'd0);

      // non-memory op
      run_op(8'h03, 32'h1, 32'h2, 32'h3, 0, 0);
      chk("nonmem_stall", 32'(stall_cnt), 32'd0);
      chk("nonmem_done", 32'(done_cnt), 32'd0);
      chk("nonmem_req", 32'(req_cnt), 32'd0);

      // back-to-back reads
      run_op(8'h05, 32'h0, 32'h20, 32'h0, 0, 0);
      run_op(8'h05, 32'h0, 32'h100, 32'h0, 0, 0);
      chk("b2b_valM", seen_valm, 32'hDEADBEEF);

      // reset during beat 2 of a write
      in_icode = 8'h0A;
      in_valA  = 32'hA1B2C3D4;
      in_valE  = 32'h200;
      in_valP  = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      chk("midrst_req_before", {31'd0, bus_req}, 32'd1);
      chk("midrst_addr_before", bus_addr, 32'h202);
      chk("midrst_wdata_before", {24'd0, bus_wdata}, 32'hB2);
      rst = 1'b0;
      #1;
      chk("midrst_req", {31'd0, bus_req}, 32'd0);
      chk("midrst_addr", bus_addr, 32'd0);
      chk("midrst_we", {31'd0, bus_we}, 32'd0);
      chk("midrst_wdata", {24'd0, bus_wdata}, 32'd0);
      chk("midrst_done", {31'd0, m_done}, 32'd0);
      chk("midrst_err", {31'd0, dmem_error}, 32'd0);
      chk("midrst_valM", valM, 32'd0);
      ref_mem[32'h200] = 8'hD4;
      ref_mem[32'h201] = 8'hC3;
      last_valm = 32'd0;
      in_icode = 8'h03;
      @(posedge clk);
      #1;
      rst = 1'b1;
      run_op(8'h05, 32'h0, 32'h200, 32'h0, 0, 1);
      chk("after_rst_low_half", {16'd0, seen_valm[15:0]}, 32'h0000C3D4);

      // randomized ops
      for (int t = 0; t < 80; t++) begin
         ic  = ic_tab[$urandom_range(11, 0)];
         sel = $urandom_range(9, 0);
         if (sel == 0)      addr = MAX_BASE;
         else if (sel == 1) addr = MAX_BASE + 32'($urandom_range(3, 1));
         else if (sel == 2) addr = $urandom | 32'h8000_0000;
         else               addr = 32'($urandom_range(MEM_SIZE - 4, 0));
         a = $urandom;
         e = $urandom;
         p = $urandom;
         if ((ic == 8'h09) || (ic == 8'h0B)) a = addr;
         else e = addr;
         run_op(ic, a, e, p, 0, 3);
      end

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      mism = 0;
      for (int i = 0; i < MEM_SIZE; i++) begin
         if (bus_mem[i] !== ref_mem[i]) mism++;
      end
      chk("mem_image", 32'(mism), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
